// File: rtl/bus_pkg.sv
// Shared bus types and widths for the serial bus slave endpoint.
// Optional read split support is enabled with SLAVE_SPLIT_EN.
package bus_pkg;

  localparam int ADDR_BITS = 16;
  localparam int DATA_BITS = 8;
  localparam int ID_BITS   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_WAIT,
    S_RD_DATA,
    S_WR_DATA,
    S_WR_COMMIT
  } slave_state_e;

endpackage

// File: rtl/bus_shift_reg.sv
// Serial-in/serial-out shift register with parallel load.
// Shifts left (MSB out first); load has priority over shift.
module bus_shift_reg
  import bus_pkg::*;
#(
  parameter int W = DATA_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         sout
);

  logic [W-1:0] q_q, q_d;

  // next value: parallel load, else shift left inserting sin
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = {q_q[W-2:0], sin};
    end
  end

  // shifter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign sout = q_q[W-1];

endmodule

// File: rtl/slave_port.sv
// Serial bus slave endpoint: address decode, write commit, read return.
// Define SLAVE_SPLIT_EN to raise split during long read waits.
module slave_port
  import bus_pkg::*;
#(
  parameter logic [ID_BITS-1:0] SLAVE_ID     = 4'h1,
  parameter int                 MEM_ADDR_W   = 12,
  parameter int                 TIMEOUT      = 64,
  parameter int                 SPLIT_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  wr_bus,
  input  logic                  master_valid,
  output logic                  slave_ready,
  output logic                  rd_bus,
  output logic                  slave_valid,
  input  logic                  master_ready,
  output logic                  ack,
  output logic                  split,
  output logic [MEM_ADDR_W-1:0] s_addr,
  output logic [DATA_BITS-1:0]  s_wr_data,
  output logic                  s_wr_en,
  output logic                  s_rd_en,
  input  logic [DATA_BITS-1:0]  s_rd_data,
  input  logic                  s_rd_valid
);

  localparam logic [5:0] TO_MAX    = 6'(TIMEOUT - 1);
  localparam logic [5:0] SPLIT_CNT = 6'(SPLIT_THRESH);

  slave_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] to_q, to_d;
  logic ack_q, ack_d;
  logic split_q, split_d;
  logic rd_en_q, rd_en_d;

  logic addr_sh, wr_sh, rd_ld, rd_sh;
  logic timed, moved;
  logic w_hs, r_hs;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wr_q, rd_q;
  logic wr_sout, rd_sout;

  assign slave_ready = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                       (state_q == S_WR_DATA);
  assign slave_valid = (state_q == S_RD_DATA);
  assign w_hs = master_valid & slave_ready;
  assign r_hs = slave_valid & master_ready;

  bus_shift_reg #(.W(ADDR_BITS)) u_addr (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .shift_en(addr_sh), .sin(wr_bus), .q(addr_q), .sout()
  );

  bus_shift_reg #(.W(DATA_BITS)) u_wdata (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .shift_en(wr_sh), .sin(wr_bus), .q(wr_q), .sout(wr_sout)
  );

  bus_shift_reg #(.W(DATA_BITS)) u_rdata (
    .clk(clk), .rst(rst), .load(rd_ld), .load_val(s_rd_data),
    .shift_en(rd_sh), .sin(1'b0), .q(rd_q), .sout(rd_sout)
  );

  // transfer sequencing, ID decode, timeout and split control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    ack_d   = ack_q;
    split_d = split_q;
    rd_en_d = 1'b0;
    addr_sh = 1'b0;
    wr_sh   = 1'b0;
    rd_ld   = 1'b0;
    rd_sh   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_hs) begin
          addr_sh = 1'b1;
          cnt_d   = 4'd1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_hs) begin
          addr_sh = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          to_d    = '0;
          if (cnt_q == 4'(ID_BITS - 1))
            ack_d = ({addr_q[ID_BITS-2:0], wr_bus} == SLAVE_ID);
          if (cnt_q == 4'd5 && !ack_q)
            state_d = S_IDLE;
          if (cnt_q == 4'd15 && ack_q) begin
            cnt_d = '0;
            if (mode) begin
              state_d = S_WR_DATA;
            end else begin
              state_d = S_RD_WAIT;
              rd_en_d = 1'b1;
            end
          end
        end
      end
      S_WR_DATA: begin
        if (w_hs) begin
          wr_sh = 1'b1;
          cnt_d = cnt_q + 4'd1;
          to_d  = '0;
          if (cnt_q == 4'd7) state_d = S_WR_COMMIT;
        end
      end
      S_WR_COMMIT: begin
        state_d = S_IDLE;
      end
      S_RD_WAIT: begin
        if (s_rd_valid) begin
          rd_ld   = 1'b1;
          cnt_d   = '0;
          to_d    = '0;
          split_d = 1'b0;
          state_d = S_RD_DATA;
        end else begin
`ifdef SLAVE_SPLIT_EN
          if (!split_q && (to_q + 6'd1) == SPLIT_CNT)
            split_d = 1'b1;
`endif
        end
      end
      S_RD_DATA: begin
        if (r_hs) begin
          rd_sh = 1'b1;
          cnt_d = cnt_q + 4'd1;
          to_d  = '0;
          if (cnt_q == 4'd7) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    timed = (state_q == S_ADDR) || (state_q == S_WR_DATA) ||
            (state_q == S_RD_WAIT) || (state_q == S_RD_DATA);
    moved = addr_sh | wr_sh | rd_sh | rd_ld;
    if (timed && !moved && !split_q) begin
      if (to_q == TO_MAX) state_d = S_IDLE;
      else                to_d    = to_q + 6'd1;
    end

    if (state_d == S_IDLE) begin
      ack_d   = 1'b0;
      split_d = 1'b0;
      cnt_d   = '0;
      to_d    = '0;
    end
  end

  // control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      ack_q   <= 1'b0;
      split_q <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      ack_q   <= ack_d;
      split_q <= split_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign rd_bus    = rd_sout;
  assign ack       = ack_q;
  assign split     = split_q;
  assign s_addr    = addr_q[MEM_ADDR_W-1:0];
  assign s_wr_data = wr_q;
  assign s_wr_en   = (state_q == S_WR_COMMIT);
  assign s_rd_en   = rd_en_q;

  logic unused_ok;
  assign unused_ok = ^{addr_q[ADDR_BITS-1:MEM_ADDR_W], rd_q, wr_sout,
                       SPLIT_CNT};

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port with a write/read scoreboard.
// Split expectations follow SLAVE_SPLIT_EN.
module tb_slave_port;

  localparam logic [3:0] SID = 4'h2;
  localparam int AW = 12;
`ifdef SLAVE_SPLIT_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, mode, wr_bus, master_valid, slave_ready;
  logic rd_bus, slave_valid, master_ready, ack, split;
  logic [AW-1:0] s_addr;
  logic [7:0] s_wr_data, s_rd_data;
  logic s_wr_en, s_rd_en, s_rd_valid;

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int rd_en_cnt = 0;
  logic [19:0] wr_q[$];
  logic rd_q[$];

  slave_port #(.SLAVE_ID(SID), .MEM_ADDR_W(AW), .TIMEOUT(64),
               .SPLIT_THRESH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .rd_bus(rd_bus), .slave_valid(slave_valid),
    .master_ready(master_ready), .ack(ack), .split(split),
    .s_addr(s_addr), .s_wr_data(s_wr_data), .s_wr_en(s_wr_en),
    .s_rd_en(s_rd_en), .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // write-strobe scoreboard and read-request counter
  always @(negedge clk) begin
    if (s_rd_en === 1'b1) rd_en_cnt++;
    if (s_wr_en === 1'b1) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        n_chk++;
        $error("FAIL wr_unexpected observed=%0h expected=none",
               {s_addr, s_wr_data});
      end else begin
        chk("wr_commit", 32'({s_addr, s_wr_data}), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int hi,
                           input int lo, input logic m);
    mode = m;
    for (int i = hi; i >= lo; i--) begin
      chk("slave_ready", 32'(slave_ready), 1);
      wr_bus = v[i];
      master_valid = 1'b1;
      tick();
    end
    master_valid = 1'b0;
    wr_bus = 1'b0;
  endtask

  task automatic send_addr(input logic [15:0] a, input logic m);
    send_bits(a, 15, 13, m);
    chk("ack_pre", 32'(ack), 0);
    send_bits(a, 12, 12, m);
    chk("ack_match", 32'(ack), 1);
    send_bits(a, 11, 0, m);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    send_addr(a, 1'b1);
    wr_q.push_back({a[11:0], d});
    send_bits({8'h00, d}, 7, 0, 1'b1);
    chk("wr_en_on", 32'(s_wr_en), 1);
    tick();
    chk("wr_en_off", 32'(s_wr_en), 0);
    chk("ack_clear", 32'(ack), 0);
  endtask

  task automatic recv_bits(input int n, input bit pause);
    for (int i = 0; i < n; i++) begin
      master_ready = 1'b1;
      if (pause && i == 3) begin
        master_ready = 1'b0;
        tick();
        master_ready = 1'b1;
      end
      chk("rd_valid", 32'(slave_valid), 1);
      chk("rd_bit", 32'(rd_bus), 32'(rd_q.pop_front()));
      tick();
    end
    master_ready = 1'b0;
  endtask

  task automatic start_read(input logic [15:0] a, input logic [7:0] d,
                            input int lat);
    send_addr(a, 1'b0);
    chk("rd_en", 32'(s_rd_en), 1);
    chk("rd_addr", 32'(s_addr), 32'(a[11:0]));
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("rd_wait_idle", 32'(slave_valid), 0);
    end
    chk("split_wait", 32'(split), 32'(SPLIT_ON && lat >= 4));
    s_rd_valid = 1'b1;
    s_rd_data = d;
    for (int i = 7; i >= 0; i--) rd_q.push_back(d[i]);
    tick();
    s_rd_valid = 1'b0;
    s_rd_data = 8'h00;
    chk("split_drop", 32'(split), 0);
  endtask

  initial begin
    rst = 1'b1;
    mode = 1'b0;
    wr_bus = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    s_rd_data = 8'h00;
    s_rd_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(slave_ready), 1);
    chk("rst_outs", 32'({rd_bus, slave_valid, ack, split, s_wr_en, s_rd_en}), 0);
    chk("rst_addr", 32'(s_addr), 0);
    chk("rst_wdata", 32'(s_wr_data), 0);
    rst = 1'b0;
    tick();

    do_write(16'h2A5C, 8'hB7);

    start_read(16'h2010, 8'h3C, 2);
    recv_bits(8, 1'b1);
    chk("rd_done", 32'({slave_valid, ack}), 0);

    send_bits(16'h5000, 15, 12, 1'b0);
    chk("ack_mismatch", 32'(ack), 0);
    send_bits(16'h5000, 11, 10, 1'b0);
    chk("ack_mismatch6", 32'(ack), 0);
    start_read(16'h2FFF, 8'hA5, 1);
    recv_bits(8, 1'b0);

    start_read(16'h2030, 8'hC3, 10);
    recv_bits(8, 1'b0);

    send_addr(16'h2123, 1'b1);
    send_bits(16'h005A, 7, 5, 1'b1);
    repeat (60) tick();
    chk("to_hold", 32'(ack), 1);
    repeat (6) tick();
    chk("to_abort", 32'(ack), 0);
    do_write(16'h2001, 8'h11);

    start_read(16'h2002, 8'h96, 1);
    recv_bits(3, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs",
        32'({rd_bus, slave_valid, ack, split, s_wr_en, s_rd_en}), 0);
    chk("mid_rst_ready", 32'(slave_ready), 1);
    chk("mid_rst_addr", 32'({s_addr, s_wr_data}), 0);
    rd_q.delete();
    tick();
    rst = 1'b0;
    s_rd_valid = 1'b1;
    s_rd_data = 8'hFF;
    tick();
    s_rd_valid = 1'b0;
    s_rd_data = 8'h00;
    chk("late_rd_valid", 32'({slave_valid, rd_bus}), 0);
    tick();

    chk("wr_count", 32'(wr_cnt), 2);
    chk("rd_en_count", 32'(rd_en_cnt), 4);
    chk("wr_left", 32'(wr_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/slave_port.md
# slave_port

Serial bus slave endpoint: the counterpart of the master port on the other side of the system bus. It shifts in the 16-bit address (MSB first) on `wr_bus`, decodes the 4-bit slave ID, and acks on a match. It then either shifts in 8 write-data bits and commits them to a local memory, or reads the local memory and shifts 8 data bits out on `rd_bus`. It sits between the bus interconnect and one slave memory or peripheral.

## Interface
- `SLAVE_ID`, 4'h1: matched against address bits [15:12].
- `MEM_ADDR_W`, 12: local address width, taken from address bits [MEM_ADDR_W-1:0]. Must be ≤ 12.
- `TIMEOUT`, 64: number of idle cycles after which an in-progress transfer is aborted.
- `SPLIT_THRESH`, 4: read-wait cycles before `split` is raised (with `SLAVE_SPLIT_EN` only).
- `clk` input 1: the single clock; all state is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mode` input 1: 1 = write, 0 = read. Sampled with the last address bit.
- `wr_bus` input 1: serial address/write data, MSB first.
- `master_valid` input 1: `wr_bus` bit valid.
- `slave_ready` output 1: slave accepts a `wr_bus` bit.
- `rd_bus` output 1: serial read data, MSB first.
- `slave_valid` output 1: `rd_bus` bit valid.
- `master_ready` input 1: master accepts an `rd_bus` bit.
- `ack` output 1: address-ID match.
- `split` output 1: slave has suspended the read data phase.
- `s_addr` output MEM_ADDR_W: memory address.
- `s_wr_data` output 8: memory write data.
- `s_wr_en` output 1: one-cycle write strobe.
- `s_rd_en` output 1: one-cycle read request.
- `s_rd_data` input 8: memory read data.
- `s_rd_valid` input 1: `s_rd_data` valid. Arrives ≥1 cycle after `s_rd_en`.

## Operation
- Write-bit handshake: a bit transfers when `master_valid & slave_ready`.
- Read-bit handshake: a bit transfers when `slave_valid & master_ready`.
- States: IDLE, ADDR, RD_WAIT, RD_DATA, WR_DATA, WR_COMMIT.
- IDLE: `slave_ready`=1. The first accepted bit is address bit 15; it loads a 4-bit bit counter to 1 and moves to ADDR.
- ADDR: `slave_ready`=1. Shifts bits into a 16-bit register.
  - When the 4th bit is accepted, `ack` is registered to (addr[15:12]==SLAVE_ID).
  - `ack` is held until return to IDLE.
  - On a mismatch, the block keeps `slave_ready` high through bit 6, then returns to IDLE.
  - On a match, after the 16th bit: if `mode`=1, go to WR_DATA; otherwise pulse `s_rd_en` with `s_addr` and go to RD_WAIT.
- WR_DATA: `slave_ready`=1. Shifts 8 bits. After the 8th bit, go to WR_COMMIT.
- WR_COMMIT: `s_wr_en`=1 for one cycle with `s_addr`/`s_wr_data` stable, then go to IDLE.
- RD_WAIT: on `s_rd_valid`, load the 8-bit output shifter and go to RD_DATA.
- RD_DATA: `slave_valid`=1, `rd_bus`=shifter[7]. The shifter shifts left on each handshake. After the 8th handshake, go to IDLE.
- Timeout: in ADDR, WR_DATA, RD_DATA, or RD_WAIT, a 6-bit counter increments on every cycle without a handshake and clears on each handshake. At TIMEOUT-1 the block aborts to IDLE. No `s_wr_en` is issued. A pending `s_rd_valid` is discarded.
- `s_rd_valid` outside RD_WAIT is ignored.

## Timing
- Reset values of all outputs: `slave_ready`=1 (IDLE); `rd_bus`, `slave_valid`, `ack`, `split`, `s_wr_en`, `s_rd_en`, `s_addr`, `s_wr_data` = 0.
- Reset mid-transfer returns to IDLE immediately. No memory strobe is emitted.
- `ack` rises exactly 1 cycle after the 4th address handshake. It is therefore valid when the master checks it on the 6th.
- Write: `s_wr_en` fires 1 cycle after the 8th data handshake.
- Read: `s_rd_en` fires 1 cycle after the 16th address handshake. The first `rd_bus` bit is valid 1 cycle after `s_rd_valid`.
- All outputs are registered or decoded from state only; no input→output combinational paths.

## Configuration
- `SLAVE_SPLIT_EN` defined:
  - In RD_WAIT, once the wait count reaches SPLIT_THRESH, `split` goes high.
  - `split` drops in the cycle the shifter loads, i.e. together with `slave_valid` rising.
  - The timeout counter is frozen while `split`=1.
- `SLAVE_SPLIT_EN` undefined: `split` is tied to 0, and RD_WAIT is subject to the timeout.

## Structure
- Shared package `bus_pkg`:
  - the slave state enum;
  - `ADDR_BITS`=16, `DATA_BITS`=8, `ID_BITS`=4.
- One natural sub-module, `bus_shift_reg`: parameterised width, serial-in/serial-out, with parallel load. Instantiated for the address, write-data and read-data shifters.

## Test plan
- SLAVE_ID=2: write to 0x2A5C, data 0xB7 → `ack` high after bit 4; `s_wr_en` pulses once with `s_addr`=0xA5C, `s_wr_data`=0xB7.
- Read from 0x2010, memory returns 0x3C after 2 cycles → `rd_bus` emits 0,0,1,1,1,1,0,0; block returns to IDLE.
- Address 0x5000 with SLAVE_ID=2 → `ack` stays 0; block back in IDLE after bit 6; no `s_rd_en`/`s_wr_en`.
- `master_valid` dropped after 3 write-data bits for 64 cycles → abort to IDLE, no `s_wr_en`; next transfer 0x2001/0x11 completes normally.
- `SLAVE_SPLIT_EN`, memory latency 10 → `split` high from wait cycle 4 until the data loads; 8 bits are then delivered correctly.
- `rst` asserted mid-RD_DATA → all outputs at reset values next cycle; a late `s_rd_valid` is ignored.
